// File: rtl/ifu_fetch_queue.sv
// Instruction-fetch stage: owns the fetch PC, drives the I-cache request and
// buffers returned instructions in a small FIFO toward decode.
module ifu_fetch_queue #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
    parameter int unsigned QDEPTH   = 2,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        icache_valid,
    output logic [63:0] icache_pc,
    input  logic        icache_rsp_valid,
    input  logic [31:0] icache_inst,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [63:0] id_pc,
    output logic [31:0] id_inst,
    output logic        id_exc
);

    localparam int unsigned PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(QDEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(QDEPTH);

    typedef enum logic [1:0] {
        KILL  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } state_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
        logic        exc;
    } entry_t;

    state_t             state_q, state_d;
    logic [63:0]        pc_q, pc_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    entry_t             mem_q [QDEPTH];

    logic               push_c;
    logic               pop_c;
    entry_t             push_entry_c;
    logic               not_full_c;
    logic               aligned_c;
    entry_t             head_c;

    assign not_full_c = (count_q < DEPTH_C);
    assign aligned_c  = (pc_q[1:0] == 2'b00);

    // Next-state, request and queue control; a redirect overrides everything.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        push_c       = 1'b0;
        pop_c        = 1'b0;
        push_entry_c = '0;
        icache_valid = 1'b0;
        count_d      = count_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;

        case (state_q)
            KILL: begin
                state_d = FETCH;
            end
            FETCH: begin
                if (not_full_c && aligned_c) begin
                    icache_valid = 1'b1;
                    if (icache_rsp_valid) begin
                        push_c       = 1'b1;
                        push_entry_c = '{pc: pc_q, inst: icache_inst, exc: 1'b0};
                        pc_d         = pc_q + 64'd4;
                    end
                end else if (not_full_c) begin
                    // Misaligned PC: queue a faulting NOP and stop fetching.
                    push_c       = 1'b1;
                    push_entry_c = '{pc: pc_q, inst: NOP_INST, exc: 1'b1};
                    state_d      = HALT;
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = KILL;
            end
        endcase

        pop_c = (count_q != '0) && id_ready;

        if (push_c) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push_c && !pop_c) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop_c && !push_c) begin
            count_d = count_q - CNT_W'(1);
        end

        if (redirect_valid) begin
            icache_valid = 1'b0;
            push_c       = 1'b0;
            pop_c        = 1'b0;
            state_d      = KILL;
            pc_d         = redirect_pc;
            count_d      = '0;
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
        end
    end

    // Control state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= KILL;
            pc_q     <= RESET_PC;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Queue storage; cleared on reset so the head reads zero afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < QDEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_c) begin
            mem_q[wr_ptr_q] <= push_entry_c;
        end
    end

    assign head_c    = mem_q[rd_ptr_q];
    assign icache_pc = pc_q;
    assign id_valid  = (count_q != '0);
    assign id_pc     = head_c.pc;
    assign id_inst   = head_c.inst;
    assign id_exc    = head_c.exc;

endmodule
